// File: rtl/life_arbiter.sv
// Game-of-Life board arbiter: serialises clear, pattern-stamp and generation
// requests onto a single board RAM port and the generation engine handshake.
module life_arbiter #(
  parameter int COLS = 64,
  parameter int ROWS = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            freeze,
  input  logic            stamp_req,
  input  logic            clear_req,
  input  logic [7:0]      cursor_x,
  input  logic [7:0]      cursor_y,
  input  logic [63:0]     pattern_mat,
  output logic            gen_start,
  input  logic            gen_done,
  output logic [5:0]      row_addr,
  input  logic [COLS-1:0] row_rd_data,
  output logic            row_wr_en,
  output logic [COLS-1:0] row_wr_data,
  output logic            busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GEN_START = 3'd1;
  localparam logic [2:0] S_GEN_WAIT  = 3'd2;
  localparam logic [2:0] S_ST_RD     = 3'd3;
  localparam logic [2:0] S_ST_WAIT   = 3'd4;
  localparam logic [2:0] S_ST_WR     = 3'd5;
  localparam logic [2:0] S_CLR       = 3'd6;

  localparam logic [6:0] COLS_W    = 7'(COLS);
  localparam logic [6:0] ROWS_W    = 7'(ROWS);
  localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);
  localparam logic [7:0] ROWS_B    = 8'(ROWS);

  logic [2:0]  state_q, state_d;
  logic        gen_pend_q, gen_pend_d;
  logic        st_pend_q, st_pend_d;
  logic        clr_pend_q, clr_pend_d;
  logic [5:0]  cx_q, cx_d;
  logic [5:0]  cy_q, cy_d;
  logic [63:0] pat_q, pat_d;
  logic [2:0]  st_row_q, st_row_d;
  logic [5:0]  clr_row_q, clr_row_d;

  logic            in_stamp, in_clr, st_last, clr_last;
  logic            st_absorb, clr_absorb;
  logic [6:0]      row_sum;
  logic [5:0]      st_addr;
  logic [7:0]      pat_byte;
  logic [COLS-1:0] byte_wide;
  logic [2*COLS-1:0] byte_dbl;
  logic [COLS-1:0] stamp_mask;

  // Only the low six cursor_x bits select a column.
  logic unused_cursor_hi;
  assign unused_cursor_hi = ^cursor_x[7:6];

  assign in_stamp = (state_q == S_ST_RD) || (state_q == S_ST_WAIT) || (state_q == S_ST_WR);
  assign in_clr   = (state_q == S_CLR);
  assign st_last  = (state_q == S_ST_WR) && (st_row_q == 3'd7);
  assign clr_last = in_clr && (clr_row_q == LAST_ROW);

  // A repeat request is dropped while its own operation runs, except on the
  // final cycle, where it is already a request for the next round.
  assign st_absorb  = in_stamp && !st_last;
  assign clr_absorb = in_clr && !clr_last;

  always_comb begin
    row_sum = {1'b0, cy_q} + {4'b0, st_row_q};
    st_addr = (row_sum >= ROWS_W) ? 6'(row_sum - ROWS_W) : row_sum[5:0];
  end

  // Toroidal rotate-left: take the upper half of the doubled word after shift.
  always_comb begin
    pat_byte   = pat_q[{st_row_q, 3'b000} +: 8];
    byte_wide  = {{(COLS-8){1'b0}}, pat_byte};
    byte_dbl   = {byte_wide, byte_wide} << cx_q;
    stamp_mask = byte_dbl[2*COLS-1:COLS];
  end

  always_comb begin
    state_d    = state_q;
    gen_pend_d = gen_pend_q | (tick & ~freeze);
    st_pend_d  = st_pend_q  | (stamp_req & ~st_absorb);
    clr_pend_d = clr_pend_q | (clear_req & ~clr_absorb);
    cx_d       = cx_q;
    cy_d       = cy_q;
    pat_d      = pat_q;
    st_row_d   = st_row_q;
    clr_row_d  = clr_row_q;

    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          state_d    = S_CLR;
          clr_pend_d = 1'b0;
          clr_row_d  = 6'd0;
        end else if (st_pend_q) begin
          state_d   = S_ST_RD;
          st_pend_d = 1'b0;
          st_row_d  = 3'd0;
          cx_d      = 6'({1'b0, cursor_x[5:0]} % COLS_W);
          cy_d      = (cursor_y >= ROWS_B) ? LAST_ROW : cursor_y[5:0];
          pat_d     = pattern_mat;
        end else if (gen_pend_q) begin
          state_d    = S_GEN_START;
          gen_pend_d = 1'b0;
        end
      end
      S_GEN_START: state_d = S_GEN_WAIT;
      S_GEN_WAIT:  if (gen_done) state_d = S_IDLE;
      S_ST_RD:     state_d = S_ST_WAIT;
      S_ST_WAIT:   state_d = S_ST_WR;
      S_ST_WR: begin
        if (st_row_q == 3'd7) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_ST_RD;
          st_row_d = st_row_q + 3'd1;
        end
      end
      S_CLR: begin
        if (clr_last) state_d = S_IDLE;
        else          clr_row_d = clr_row_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gen_pend_q <= 1'b0;
      st_pend_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      cx_q       <= 6'd0;
      cy_q       <= 6'd0;
      pat_q      <= 64'd0;
      st_row_q   <= 3'd0;
      clr_row_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      gen_pend_q <= gen_pend_d;
      st_pend_q  <= st_pend_d;
      clr_pend_q <= clr_pend_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      pat_q      <= pat_d;
      st_row_q   <= st_row_d;
      clr_row_q  <= clr_row_d;
    end
  end

  // Outputs decode straight from reset-cleared flops, so rst zeroes them at once.
  assign busy        = (state_q != S_IDLE);
  assign gen_start   = (state_q == S_GEN_START);
  assign row_wr_en   = (state_q == S_ST_WR) || in_clr;
  assign row_addr    = in_stamp ? st_addr : (in_clr ? clr_row_q : 6'd0);
  assign row_wr_data = (state_q == S_ST_WR) ? (row_rd_data | stamp_mask) : '0;

endmodule

// File: tb/tb_life_arbiter.sv
// Scoreboard bench for life_arbiter: directed requests push expected RAM
// writes / gen_start pulses; a negedge monitor pops and compares them.
module tb_life_arbiter;
  localparam int COLS = 64;
  localparam int ROWS = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, freeze = 1'b0, stamp_req = 1'b0, clear_req = 1'b0, gen_done = 1'b0;
  logic [7:0]  cursor_x = 8'd0, cursor_y = 8'd0;
  logic [63:0] pattern_mat = 64'd0;
  logic        gen_start, row_wr_en, busy;
  logic [5:0]  row_addr;
  logic [COLS-1:0] row_rd_data, row_wr_data;

  life_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze), .stamp_req(stamp_req),
    .clear_req(clear_req), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .pattern_mat(pattern_mat), .gen_start(gen_start), .gen_done(gen_done),
    .row_addr(row_addr), .row_rd_data(row_rd_data), .row_wr_en(row_wr_en),
    .row_wr_data(row_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_gen;
    logic [5:0]  addr;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          runs[$];
  int          n_tests = 0, n_fail = 0;
  int          gen_cnt = 0, run = 0;
  logic [63:0] mem [64];
  logic [63:0] ref_mem [ROWS];
  ev_t         act_ev, exp_ev;

  // Board RAM with synchronous read.
  always @(posedge clk) begin
    if (row_wr_en) mem[row_addr] <= row_wr_data;
    row_rd_data <= mem[row_addr];
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) run++;
    else if (run > 0) begin runs.push_back(run); run = 0; end
    if (row_wr_en || gen_start) begin
      act_ev = '{is_gen: gen_start, addr: row_addr, data: row_wr_data};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got gen=%0b addr=%0d data=%h with nothing expected",
                 act_ev.is_gen, act_ev.addr, act_ev.data);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL sb_event: got gen=%0b addr=%0d data=%h expected gen=%0b addr=%0d data=%h",
                   act_ev.is_gen, act_ev.addr, act_ev.data, exp_ev.is_gen, exp_ev.addr, exp_ev.data);
        end
      end
    end
    if (gen_start) gen_cnt++;
  end

  task automatic push_clear();
    for (int a = 0; a < ROWS; a++) begin
      ref_mem[a] = 64'd0;
      exp_q.push_back('{is_gen: 1'b0, addr: 6'(a), data: 64'd0});
    end
  endtask

  task automatic push_stamp(input int x, input int y, input logic [63:0] pat, input int nrows);
    int cx, cy, a;
    logic [63:0] m;
    cx = x % 64;
    cy = (y >= ROWS) ? ROWS - 1 : y;
    for (int r = 0; r < nrows; r++) begin
      a = (cy + r) % ROWS;
      m = 64'd0;
      for (int c = 0; c < 8; c++)
        if (pat[8*r + c]) m[(cx + c) % 64] = 1'b1;
      ref_mem[a] = ref_mem[a] | m;
      exp_q.push_back('{is_gen: 1'b0, addr: 6'(a), data: ref_mem[a]});
    end
  endtask

  task automatic push_gen();
    exp_q.push_back('{is_gen: 1'b1, addr: 6'd0, data: 64'd0});
  endtask

  task automatic req_stamp(input int x, input int y, input logic [63:0] pat);
    @(negedge clk);
    cursor_x = 8'(x); cursor_y = 8'(y); pattern_mat = pat; stamp_req = 1'b1;
    @(negedge clk);
    stamp_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int idle_cnt;
    idle_cnt = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      idle_cnt = busy ? 0 : idle_cnt + 1;
      if (idle_cnt >= 3 && exp_q.size() == 0) break;
    end
    check64({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_gen_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (gen_start) ok = 1'b1;
    end
    check64({name, "_gen_start_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic finish_gen();
    repeat (3) @(negedge clk);
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  function automatic int next_run();
    return (runs.size() > 0) ? runs.pop_front() : -1;
  endfunction

  task automatic check_reset_outputs(input string name);
    check64({name, "_gen_start"}, 64'(gen_start), 64'd0);
    check64({name, "_wr_en"},     64'(row_wr_en), 64'd0);
    check64({name, "_addr"},      64'(row_addr),  64'd0);
    check64({name, "_wr_data"},   row_wr_data,    64'd0);
    check64({name, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    int g0;
    bit hit;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Clear the board first so RAM contents are known.
    runs.delete();
    push_clear();
    @(negedge clk); clear_req = 1'b1; @(negedge clk); clear_req = 1'b0;
    wait_idle("clear0", 200);
    check64("clear0_busy_len", 64'(next_run()), 64'd48);

    // Single cell at (10,5).
    runs.delete();
    push_stamp(10, 5, 64'h1, 8);
    req_stamp(10, 5, 64'h1);
    wait_idle("stamp1", 200);
    check64("stamp1_busy_len", 64'(next_run()), 64'd24);
    check64("stamp1_row5", mem[5], 64'h0000_0000_0000_0400);
    check64("stamp1_row6", mem[6], 64'd0);

    // Column wrap at (62,46); row 5 must keep its earlier cell.
    push_stamp(62, 46, 64'hFF00, 8);
    req_stamp(62, 46, 64'hFF00);
    wait_idle("stamp_wrap", 200);
    check64("stamp_wrap_row47", mem[47], 64'hC000_0000_0000_003F);
    check64("stamp_wrap_row5_kept", mem[5], 64'h0000_0000_0000_0400);

    // cursor_x=70 -> column 6; cursor_y=200 clamps to row 47, wraps to row 0.
    push_stamp(70, 200, 64'h8101, 8);
    req_stamp(70, 200, 64'h8101);
    wait_idle("stamp_clamp", 200);
    check64("stamp_clamp_row47", mem[47], 64'hC000_0000_0000_007F);
    check64("stamp_clamp_row0", mem[0], 64'h0000_0000_0000_2040);

    // Frozen tick is dropped; stray gen_done in IDLE is ignored.
    g0 = gen_cnt;
    @(negedge clk); freeze = 1'b1; tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (6) @(negedge clk);
    freeze = 1'b0;
    gen_done = 1'b1; @(negedge clk); gen_done = 1'b0;
    repeat (6) @(negedge clk);
    check64("freeze_no_gen", 64'(gen_cnt - g0), 64'd0);
    check64("stray_done_idle", 64'(busy), 64'd0);

    // Generation with a stamp requested during GEN_WAIT.
    push_gen();
    @(negedge clk); tick = 1'b1; @(negedge clk); tick = 1'b0;
    wait_gen_start("gen1");
    push_stamp(20, 10, 64'h3, 8);
    req_stamp(20, 10, 64'h3);
    repeat (3) @(negedge clk);
    check64("gen_wait_no_preempt", {62'd0, busy, row_wr_en}, 64'd2);
    gen_done = 1'b1; @(negedge clk); gen_done = 1'b0;
    check64("gen_done_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check64("stamp_after_gen_addr", {57'd0, busy, row_addr}, {57'd0, 1'b1, 6'd10});
    wait_idle("gen1", 200);

    // Simultaneous clear, stamp, tick: CLR, then stamp, then gen.
    runs.delete();
    push_clear();
    push_stamp(1, 2, 64'h10, 8);
    push_gen();
    @(negedge clk);
    cursor_x = 8'd1; cursor_y = 8'd2; pattern_mat = 64'h10;
    clear_req = 1'b1; stamp_req = 1'b1; tick = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; stamp_req = 1'b0; tick = 1'b0;
    wait_gen_start("prio");
    finish_gen();
    wait_idle("prio", 200);
    check64("prio_run_clr", 64'(next_run()), 64'd48);
    check64("prio_run_stamp", 64'(next_run()), 64'd24);
    check64("prio_run_gen", 64'(next_run()), 64'd4);
    check64("prio_row2", mem[2], 64'h0000_0000_0000_0020);

    // Reset during stamp row 3 with tick and clear pending.
    push_stamp(0, 20, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    req_stamp(0, 20, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    clear_req = 1'b1; tick = 1'b1; @(negedge clk); clear_req = 1'b0; tick = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (busy && row_addr == 6'd23) hit = 1'b1;
      else @(negedge clk);
    end
    check64("rst_mid_reached_row3", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    g0 = gen_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runs.delete();
    repeat (100) @(negedge clk);
    check64("rst_no_gen", 64'(gen_cnt - g0), 64'd0);
    check64("rst_no_activity", 64'(runs.size()), 64'd0);
    check64("rst_row22", mem[22], 64'h0000_0000_0000_00FF);
    check64("rst_row23_untouched", mem[23], 64'd0);
    check64("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
